// File: rtl/tester_pkg.sv
// Shared helpers for the front-panel button debouncer bank.
// Cycle conversion, counter sizing and the per-channel output bundle.
package tester_pkg;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic long_press;
  } ch_out_t;

  function automatic int us_to_cycles(input longint freq,
                                      input longint us);
    return int'((freq * us) / longint'(1_000_000));
  endfunction

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop sync, symmetric debounce,
// registered press/release pulses and a one-shot long-press.
module debounce_channel
  import tester_pkg::*;
#(
  parameter int DB_CYC     = 4,
  parameter int LONG_CYC   = 20,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic    clk,
  input  logic    rstn,
  input  logic    button_i,
  output ch_out_t out_o
);

  localparam int DW = cnt_w(DB_CYC);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYC - 1);

  logic          s1_q, s2_q, s;
  logic          lvl_q, lvl_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          long_p;

  assign s = s2_q ^ ACTIVE_LOW;

  always_comb begin
    lvl_d   = lvl_q;
    dcnt_d  = dcnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (1'b1)
      (s == lvl_q): dcnt_d = '0;
      ((s != lvl_q) && (dcnt_q == DB_LAST)): begin
        lvl_d   = s;
        dcnt_d  = '0;
        press_d = s;
        rel_d   = ~s;
      end
      default: dcnt_d = dcnt_q + 1'b1;
    endcase
  end

  // Sync flops reset to the raw idle level so reset never looks like a press.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q    <= ACTIVE_LOW;
      s2_q    <= ACTIVE_LOW;
      lvl_q   <= 1'b0;
      dcnt_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      s1_q    <= button_i;
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      dcnt_q  <= dcnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  generate
    if (LONG_CYC > 0) begin : g_long
      localparam int LW = cnt_w(LONG_CYC);
      localparam logic [LW-1:0] L_MAX = LW'(LONG_CYC);

      logic [LW-1:0] lcnt_q, lcnt_d;
      logic          long_q, long_d;

      always_comb begin
        lcnt_d = lcnt_q;
        long_d = 1'b0;
        if (!lvl_q) begin
          lcnt_d = '0;
        end else if (lcnt_q < L_MAX) begin
          lcnt_d = lcnt_q + 1'b1;
          long_d = (lcnt_d == L_MAX);
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          lcnt_q <= '0;
          long_q <= 1'b0;
        end else begin
          lcnt_q <= lcnt_d;
          long_q <= long_d;
        end
      end

      assign long_p = long_q;
    end else begin : g_nolong
      assign long_p = 1'b0;
    end
  endgenerate

  assign out_o = '{lvl_q, press_q, rel_q, long_p};

endmodule

// File: rtl/button_debouncer_bank.sv
// Bank of N_CH independent button debouncers for the tester panel.
// Timing parameters are given in us and converted to cycles here.
module button_debouncer_bank
  import tester_pkg::*;
#(
  parameter int FREQ        = 100_000_000,
  parameter int N_CH        = 4,
  parameter int DEBOUNCE_US = 500,
  parameter int LONG_US     = 1_000_000,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] long_press
);

  localparam int DB_CYC   = us_to_cycles(FREQ, DEBOUNCE_US);
  localparam int LONG_CYC = us_to_cycles(FREQ, LONG_US);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_out_t o;

    debounce_channel #(
      .DB_CYC    (DB_CYC),
      .LONG_CYC  (LONG_CYC),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .clk     (clk),
      .rstn    (rstn),
      .button_i(button[i]),
      .out_o   (o)
    );

    assign level[i]      = o.level;
    assign press[i]      = o.press;
    assign release_o[i]  = o.rel;
    assign long_press[i] = o.long_press;
  end

endmodule

// File: tb/tb_button_debouncer_bank.sv
// Scoreboard bench: stimulus queues expected pulse events,
// a negedge monitor pops and compares whenever any pulse fires.
module tb_button_debouncer_bank;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] btn, btn_al;
  logic [1:0] lvl_a, prs_a, rel_a, lng_a;
  logic [1:0] lvl_b, prs_b, rel_b, lng_b;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  typedef struct {
    int         cyc;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] l;
    logic [3:0] v;
  } ev_t;

  ev_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_debouncer_bank #(
    .FREQ(1_000_000), .N_CH(2), .DEBOUNCE_US(4),
    .LONG_US(20), .ACTIVE_LOW(1'b0)
  ) u_dut (
    .clk(clk), .rstn(rstn), .button(btn),
    .level(lvl_a), .press(prs_a),
    .release_o(rel_a), .long_press(lng_a)
  );

  button_debouncer_bank #(
    .FREQ(1_000_000), .N_CH(2), .DEBOUNCE_US(4),
    .LONG_US(20), .ACTIVE_LOW(1'b1)
  ) u_al (
    .clk(clk), .rstn(rstn), .button(btn_al),
    .level(lvl_b), .press(prs_b),
    .release_o(rel_b), .long_press(lng_b)
  );

  wire [3:0] p_all = {prs_b, prs_a};
  wire [3:0] r_all = {rel_b, rel_a};
  wire [3:0] l_all = {lng_b, lng_a};
  wire [3:0] v_all = {lvl_b, lvl_a};

  initial begin
    forever begin
      @(negedge clk);
      if ((|{p_all, r_all, l_all}) === 1'b1) begin
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event cyc=%0d p=%b r=%b l=%b v=%b required none",
                   cyc, p_all, r_all, l_all, v_all);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.p !== p_all || e.r !== r_all ||
              e.l !== l_all || e.v !== v_all) begin
            n_fail++;
            $display("FAIL event got cyc=%0d p=%b r=%b l=%b v=%b required cyc=%0d p=%b r=%b l=%b v=%b",
                     cyc, p_all, r_all, l_all, v_all,
                     e.cyc, e.p, e.r, e.l, e.v);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int dc, input logic [3:0] p,
                      input logic [3:0] r, input logic [3:0] l,
                      input logic [3:0] v);
    ev_t e;
    e = '{cyc + dc, p, r, l, v};
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", nm, got, exp);
    end
  endtask

  initial begin
    rstn   = 1'b1;
    btn    = 2'b00;
    btn_al = 2'b11;
    #1 rstn = 1'b0;
    step(3);
    #1;
    chk("reset_a", {lvl_a, prs_a, rel_a, lng_a}, 8'h00);
    chk("reset_al", {lvl_b, prs_b, rel_b, lng_b}, 8'h00);
    step(1);
    rstn = 1'b1;
    step(8);
    chk("al_idle_level", {6'd0, lvl_b}, 8'h00);

    // clean press and release on ch0
    btn = 2'b01;
    push(6, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    step(10);
    btn = 2'b00;
    push(6, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    step(12);

    // bounce 1,1,1,0,1,... then stable release
    btn = 2'b01;
    step(3);
    btn = 2'b00;
    step(1);
    btn = 2'b01;
    push(6, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    step(10);
    btn = 2'b00;
    push(6, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    step(12);

    // long press on ch1, twice
    for (int k = 0; k < 2; k++) begin
      btn = 2'b10;
      push(6, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
      push(26, 4'b0000, 4'b0000, 4'b0010, 4'b0010);
      step(k == 0 ? 40 : 30);
      btn = 2'b00;
      push(6, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
      step(12);
    end

    // async reset while ch0 held
    btn = 2'b01;
    push(6, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    step(10);
    #2;
    chk("pre_reset_level", {6'd0, lvl_a}, 8'h01);
    rstn = 1'b0;
    #1;
    chk("async_reset_a", {lvl_a, prs_a, rel_a, lng_a}, 8'h00);
    chk("async_reset_al", {lvl_b, prs_b, rel_b, lng_b}, 8'h00);
    step(2);
    rstn = 1'b1;
    push(6, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    step(10);
    btn = 2'b00;
    push(6, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    step(12);

    // active-low instance, ch0 driven low
    btn_al = 2'b10;
    push(6, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    step(10);
    btn_al = 2'b11;
    push(6, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    step(12);

    // simultaneous rise and fall on both channels
    btn = 2'b11;
    push(6, 4'b0011, 4'b0000, 4'b0000, 4'b0011);
    step(8);
    btn = 2'b00;
    push(6, 4'b0000, 4'b0011, 4'b0000, 4'b0000);
    step(12);

    // 3-cycle glitch on ch0 while ch1 rises
    btn = 2'b11;
    push(6, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    step(3);
    btn = 2'b10;
    step(7);
    btn = 2'b00;
    push(6, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    step(15);

    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_event got=none required cyc=%0d p=%b r=%b l=%b v=%b",
               e.cyc, e.p, e.r, e.l, e.v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
